pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV64 pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards, EX-resolved branch/jump redirects, and multi-cycle data-bus waits.
- Drives per-stage stall (hold register) and flush (load bubble) strobes to the stage registers.
- Tracks outstanding memory accesses with a timeout FSM and holds redirects across an in-flight instruction fetch.

Parameters:
- MEM_TIMEOUT, 255: cycles a MEM-stage access may wait for mem_ack_i before bus error; legal range 1..65535.
- CNT_W, 16: width of the internal timeout counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  ID register holds a valid instruction
- id_rs1_addr_i  in  5  ID source register 1
- id_rs2_addr_i  in  5  ID source register 2
- ex_valid_i  in  1  EX register holds a valid instruction
- ex_mm_re_i  in  1  EX instruction is a load
- ex_rd_addr_i  in  5  EX destination register
- ex_redirect_i  in  1  EX resolved a taken branch or jump
- if_busy_i  in  1  instruction fetch outstanding
- if_ack_i  in  1  instruction fetch completes this cycle
- mem_req_i  in  1  MEM stage valid with mm_re or mm_we set
- mem_ack_i  in  1  data bus completes access this cycle
- stall_if_o  out  1  hold PC/fetch
- stall_id_o  out  1  hold ID register
- stall_ex_o  out  1  hold EX register
- stall_mem_o  out  1  hold MEM register
- flush_id_o  out  1  load bubble into ID register
- flush_ex_o  out  1  load bubble into EX register
- flush_wb_o  out  1  load bubble into WB register
- redirect_pending_o  out  1  stale fetch still in flight after redirect
- bus_err_o  out  1  sticky data-bus timeout

Behaviour:
- Reset: memory FSM = M_IDLE, timeout counter = 0, redirect_pending = 0, bus_err_o = 0. All stall and flush outputs are 0 while rst_n is low.
- Memory FSM (registered):
  - M_IDLE: mem_req_i & !mem_ack_i -> M_WAIT, counter = 1. mem_req_i & mem_ack_i -> stays M_IDLE (single-cycle access, no stall).
  - M_WAIT: mem_ack_i -> M_IDLE, counter = 0. Else counter increments; at counter == MEM_TIMEOUT with no ack -> M_ERR.
  - M_ERR: terminal until reset; bus_err_o = 1.
- Mem stall (combinational, same cycle): mem_stall = (mem_req_i & !mem_ack_i) | state == M_ERR.
  - Drives stall_if, stall_id, stall_ex, stall_mem = 1 and flush_wb = 1.
  - Suppresses all redirect and load-use actions.
- Redirect, when !mem_stall & ex_redirect_i:
  - flush_id = 1, flush_ex = 1, no stalls. Redirect beats load-use.
  - If if_busy_i & !if_ack_i that cycle, set redirect_pending.
  - While redirect_pending: flush_id = 1. Clear on the cycle if_ack_i = 1; the returned stale instruction is flushed that cycle.
  - A new redirect while pending keeps pending set.
- Load-use, when !mem_stall & !ex_redirect_i:
  - Condition: ex_valid_i & ex_mm_re_i & ex_rd_addr_i != 0 & id_valid_i & (rd == rs1 | rd == rs2).
  - Action: stall_if = 1, stall_id = 1, flush_ex = 1, for exactly one cycle. The next cycle the load is in MEM and the hazard clears.
- x0 as destination never causes a load-use stall.
- Reset mid-wait: FSM and pending cleared immediately and asynchronously.
- All stall/flush outputs are combinational from inputs and registered state. No internal combinational loops with the stage registers.

Optional Feature:
- Macro: PIPELINE_HAZARD_PERF_EN.
- Defined: adds outputs stall_cycles_o [31:0] and flush_events_o [31:0], both saturating and reset to 0.
  - stall_cycles_o increments each cycle stall_if_o = 1.
  - flush_events_o increments each cycle flush_ex_o = 1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Load-use: EX load rd=5, ID rs2=5, all valid -> stall_if/stall_id/flush_ex high exactly 1 cycle; same stimulus with rd=0 -> no stall.
- Mem wait: mem_req_i held, mem_ack_i after 3 cycles -> four stalls and flush_wb high for cycles 0-2, low on the ack cycle; FSM returns to M_IDLE.
- Timeout: MEM_TIMEOUT=4, mem_req_i held with no ack -> bus_err_o rises on cycle 4, all stalls stay high until rst_n low.
- Redirect with fetch in flight: ex_redirect_i with if_busy_i=1 -> flush_id/flush_ex that cycle, redirect_pending_o=1 and flush_id held until if_ack_i 2 cycles later, then pending clears.
- Simultaneous events: redirect plus load-use -> flush_id/flush_ex, no stall; redirect during mem wait -> only mem stall until ack, then redirect flush on the next cycle.
- Async reset asserted mid-M_WAIT -> all outputs 0 immediately; after release, state M_IDLE and bus_err_o = 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-control bundle between the pipeline stage registers and pipeline_hazard_ctrl.
// PIPELINE_HAZARD_PERF_EN adds the stall/flush performance counter outputs.
interface pipeline_hazard_ctrl_if;
  logic        id_valid_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        ex_valid_i;
  logic        ex_mm_re_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_redirect_i;
  logic        if_busy_i;
  logic        if_ack_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        stall_if_o;
  logic        stall_id_o;
  logic        stall_ex_o;
  logic        stall_mem_o;
  logic        flush_id_o;
  logic        flush_ex_o;
  logic        flush_wb_o;
  logic        redirect_pending_o;
  logic        bus_err_o;
`ifdef PIPELINE_HAZARD_PERF_EN
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_events_o;

  // Controller side
  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i,
    input  ex_valid_i, ex_mm_re_i, ex_rd_addr_i, ex_redirect_i,
    input  if_busy_i, if_ack_i, mem_req_i, mem_ack_i,
    output stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
    output flush_id_o, flush_ex_o, flush_wb_o,
    output redirect_pending_o, bus_err_o,
    output stall_cycles_o, flush_events_o
  );

  // Pipeline side
  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i,
    output ex_valid_i, ex_mm_re_i, ex_rd_addr_i, ex_redirect_i,
    output if_busy_i, if_ack_i, mem_req_i, mem_ack_i,
    input  stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
    input  flush_id_o, flush_ex_o, flush_wb_o,
    input  redirect_pending_o, bus_err_o,
    input  stall_cycles_o, flush_events_o
  );
`else
  // Controller side
  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i,
    input  ex_valid_i, ex_mm_re_i, ex_rd_addr_i, ex_redirect_i,
    input  if_busy_i, if_ack_i, mem_req_i, mem_ack_i,
    output stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
    output flush_id_o, flush_ex_o, flush_wb_o,
    output redirect_pending_o, bus_err_o
  );

  // Pipeline side
  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i,
    output ex_valid_i, ex_mm_re_i, ex_rd_addr_i, ex_redirect_i,
    output if_busy_i, if_ack_i, mem_req_i, mem_ack_i,
    input  stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
    input  flush_id_o, flush_ex_o, flush_wb_o,
    input  redirect_pending_o, bus_err_o
  );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV64 pipeline: load-use, redirect and data-bus wait.
// Define PIPELINE_HAZARD_PERF_EN to add saturating stall-cycle and flush-event counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_ERR  = 2'd2
  } mem_state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  mem_state_e       mem_state_q, mem_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;

  logic mem_stall;
  logic lu_hit;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, flush_wb;

  function automatic logic load_use_hit(
    input logic       id_v,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       ex_v,
    input logic       ex_re,
    input logic [4:0] rd
  );
    return ex_v & ex_re & (rd != 5'd0) & id_v & ((rd == rs1) | (rd == rs2));
  endfunction

  // Registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_state_q <= M_IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
    end else begin
      mem_state_q <= mem_state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
    end
  end

  // Data-bus wait tracking; the counter holds the number of cycles already waited.
  always_comb begin
    mem_state_d = mem_state_q;
    cnt_d       = cnt_q;
    case (mem_state_q)
      M_IDLE: begin
        if (hz.mem_req_i && !hz.mem_ack_i) begin
          cnt_d       = ONE_C;
          mem_state_d = (TIMEOUT_C == ONE_C) ? M_ERR : M_WAIT;
        end
      end
      M_WAIT: begin
        if (hz.mem_ack_i) begin
          cnt_d       = '0;
          mem_state_d = M_IDLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
          if (cnt_d == TIMEOUT_C) begin
            mem_state_d = M_ERR;
          end
        end
      end
      M_ERR: begin
        mem_state_d = M_ERR;
      end
      default: begin
        mem_state_d = M_IDLE;
        cnt_d       = '0;
      end
    endcase
  end

  assign mem_stall = (hz.mem_req_i && !hz.mem_ack_i) || (mem_state_q == M_ERR);
  assign lu_hit    = load_use_hit(hz.id_valid_i, hz.id_rs1_addr_i, hz.id_rs2_addr_i,
                                  hz.ex_valid_i, hz.ex_mm_re_i, hz.ex_rd_addr_i);

  // Pending clears only when the stale fetch returns while the front end can act on it,
  // so the flush of that instruction is never masked by a data-bus stall.
  always_comb begin
    pending_d = pending_q;
    if (!mem_stall) begin
      if (hz.ex_redirect_i && hz.if_busy_i && !hz.if_ack_i) begin
        pending_d = 1'b1;
      end else if (hz.if_ack_i) begin
        pending_d = 1'b0;
      end
    end
  end

  // Priority: data-bus stall, then redirect, then load-use.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_wb  = 1'b0;
    if (mem_stall) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if (hz.ex_redirect_i) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (lu_hit) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
    if (pending_q && !mem_stall) begin
      flush_id = 1'b1;
    end
  end

  assign hz.stall_if_o         = rst_n & stall_if;
  assign hz.stall_id_o         = rst_n & stall_id;
  assign hz.stall_ex_o         = rst_n & stall_ex;
  assign hz.stall_mem_o        = rst_n & stall_mem;
  assign hz.flush_id_o         = rst_n & flush_id;
  assign hz.flush_ex_o         = rst_n & flush_ex;
  assign hz.flush_wb_o         = rst_n & flush_wb;
  assign hz.redirect_pending_o = pending_q;
  assign hz.bus_err_o          = (mem_state_q == M_ERR);

`ifdef PIPELINE_HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (stall_if) begin
      stall_cycles_d = sat_inc32(stall_cycles_q);
    end
    if (flush_ex) begin
      flush_events_d = sat_inc32(flush_events_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign hz.stall_cycles_o = stall_cycles_q;
  assign hz.flush_events_o = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4) with an expected-result queue.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst_n;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, pending, bus_err}
  localparam logic [8:0] E_NONE   = 9'b000000000;
  localparam logic [8:0] E_MEM    = 9'b111100100;
  localparam logic [8:0] E_MEMERR = 9'b111100101;
  localparam logic [8:0] E_LU     = 9'b110001000;
  localparam logic [8:0] E_RD     = 9'b000011000;
  localparam logic [8:0] E_PEND   = 9'b000010010;
  localparam logic [8:0] E_RDPEND = 9'b000011010;

  typedef struct {
    logic [8:0] exp;
    string      tag;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        vectors;
  int        miscompares;

  function automatic logic [8:0] observed();
    return {hz.stall_if_o, hz.stall_id_o, hz.stall_ex_o, hz.stall_mem_o,
            hz.flush_id_o, hz.flush_ex_o, hz.flush_wb_o,
            hz.redirect_pending_o, hz.bus_err_o};
  endfunction

  task automatic drive(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic exv, input logic exre, input logic [4:0] rd,
                       input logic redir, input logic busy, input logic ifack,
                       input logic req, input logic ack);
    hz.id_valid_i    = idv;
    hz.id_rs1_addr_i = rs1;
    hz.id_rs2_addr_i = rs2;
    hz.ex_valid_i    = exv;
    hz.ex_mm_re_i    = exre;
    hz.ex_rd_addr_i  = rd;
    hz.ex_redirect_i = redir;
    hz.if_busy_i     = busy;
    hz.if_ack_i      = ifack;
    hz.mem_req_i     = req;
    hz.mem_ack_i     = ack;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Push the expectation with the stimulus, compare mid-cycle, advance one clock.
  task automatic step(input logic [8:0] exp, input string tag);
    sb_entry_t e;
    logic [8:0] obs;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
    e   = sb_q.pop_front();
    obs = observed();
    vectors++;
    assert (obs === e.exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;

    // Outputs gated while in reset even with active requests
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(E_NONE, "reset_gate");
    idle_inputs();
    rst_n = 1'b1;
    step(E_NONE, "idle");

    // Load-use
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(E_LU, "lu_rs2");
    idle_inputs();
    step(E_NONE, "lu_clear");
    drive(1'b1, 5'd7, 5'd9, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(E_LU, "lu_rs1");
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(E_NONE, "lu_x0");
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(E_NONE, "lu_not_load");
    drive(1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(E_NONE, "lu_id_invalid");

    // Mem wait, acked after 3 cycles, twice back-to-back (counter must restart)
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(E_MEM, "mem_wait");
      end
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(E_NONE, "mem_ack");
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(E_NONE, "mem_single");
    idle_inputs();
    step(E_NONE, "mem_idle");

    // Redirect with fetch in flight
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(E_RD, "rd_inflight");
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(E_PEND, "rd_pending");
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(E_PEND, "rd_stale_ack");
    idle_inputs();
    step(E_NONE, "rd_cleared");

    // Redirect with no fetch outstanding never sets pending
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(E_RD, "rd_nofetch");
    idle_inputs();
    step(E_NONE, "rd_nofetch_after");

    // Redirect beats load-use
    drive(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(E_RD, "rd_over_lu");
    idle_inputs();
    step(E_NONE, "rd_over_lu_after");

    // Second redirect while pending
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(E_RD, "rd2_first");
    step(E_RDPEND, "rd2_again");
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(E_PEND, "rd2_hold");
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(E_PEND, "rd2_ack");
    idle_inputs();
    step(E_NONE, "rd2_cleared");

    // Redirect during mem wait: mem stall only, redirect acts on the ack cycle
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(E_MEM, "rdmem_0");
    step(E_MEM, "rdmem_1");
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(E_RD, "rdmem_ack");
    idle_inputs();
    step(E_NONE, "rdmem_after");

    // Async reset mid-wait, then a full timeout from a fresh counter
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(E_MEM, "arst_w0");
    step(E_MEM, "arst_w1");
    step(E_MEM, "arst_w2");
    rst_n = 1'b0;
    step(E_NONE, "arst_low");
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(E_MEM, "tmo_wait");
    end
    step(E_MEMERR, "tmo_err");
    step(E_MEMERR, "tmo_err_hold");
    idle_inputs();
    step(E_MEMERR, "tmo_sticky");
    rst_n = 1'b0;
    step(E_NONE, "tmo_reset");
    rst_n = 1'b1;
    step(E_NONE, "tmo_released");
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(E_NONE, "tmo_idle_single");

    // Reset clears a pending redirect
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(E_RD, "prst_set");
    idle_inputs();
    rst_n = 1'b0;
    step(E_NONE, "prst_low");
    rst_n = 1'b1;
    step(E_NONE, "prst_released");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
